// File: rtl/pr_pkg.sv
// Shared types and constants for the phase-run controller: the operating modes,
// the controller states and the shortest run length the counter may use.
package pr_pkg;

    typedef enum logic [1:0] {
        MODE_IDLE   = 2'd0,
        MODE_CONT   = 2'd1,
        MODE_BURST  = 2'd2,
        MODE_SINGLE = 2'd3
    } mode_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_e;

    localparam int MIN_PERIOD = 3;

endpackage

// File: rtl/pr_period_cnt.sv
// Run-period counter: counts 0..max(cfg_period,MIN_PERIOD) while enabled and
// flags the run-start cycle (count 0) and the last cycle of each run.
module pr_period_cnt
    import pr_pkg::*;
#(
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 en,
    input  logic                 start_en,
    input  logic [CNT_WIDTH-1:0] cfg_period,
    output logic                 start,
    output logic                 last
);

    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic [CNT_WIDTH-1:0] per_q, per_d;
    logic [CNT_WIDTH-1:0] per_eff;

    // Count 0 is never the terminal count, so per_q is only compared once it holds this run's value.
    assign last  = en && (cnt_q != '0) && (cnt_q == per_q);
    assign start = start_en && (cnt_q == '0);

    always_comb begin
        per_eff = (cfg_period < CNT_WIDTH'(MIN_PERIOD)) ? CNT_WIDTH'(MIN_PERIOD) : cfg_period;
        cnt_d   = cnt_q;
        per_d   = per_q;
        if (!en) begin
            cnt_d = '0;
        end else if (last) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CNT_WIDTH'(1);
        end
        if (en && (cnt_q == '0)) begin
            per_d = per_eff;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
            per_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            per_q <= per_d;
        end
    end

endmodule

// File: rtl/pr_run_ctrl.sv
// Phase-run controller: sequences measurement runs, captures the first phase
// strobe of each participating channel and presents one result per run.
module pr_run_ctrl
    import pr_pkg::*;
#(
    parameter int CHANNELS  = 3,
    parameter int PH_WIDTH  = 16,
    parameter int CNT_WIDTH = 16,
    parameter int RUNS      = 3
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [1:0]                       cfg_mode,
    input  logic                             cfg_arm,
    input  logic [CNT_WIDTH-1:0]             cfg_period,
    input  logic [CHANNELS-1:0]              ch_mask,
    output logic                             start,
    input  logic [CHANNELS-1:0]              ch_valid,
    input  logic [CHANNELS*PH_WIDTH-1:0]     ch_phase,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [CHANNELS*PH_WIDTH-1:0]     out_phase,
    output logic [(CHANNELS-1)*PH_WIDTH-1:0] out_diff,
    output logic [CHANNELS-1:0]              out_timeout,
    output logic [15:0]                      out_run,
    output logic [7:0]                       overrun_cnt,
    output logic                             busy
);

    localparam int RW = $clog2(RUNS + 1);

    state_e                        state_q, state_d;
    mode_e                         mode_q, mode_d;
    logic [RW-1:0]                 rem_q, rem_d;
    logic [15:0]                   run_idx_q, run_idx_d;
    logic [15:0]                   cur_run_q, cur_run_d;
    logic                          run_open_q, run_open_d;
    logic [CHANNELS-1:0]           mask_q, mask_d;
    logic [CHANNELS-1:0]           cap_q, cap_d;
    logic [CHANNELS*PH_WIDTH-1:0]  ph_q, ph_d;
    logic                          out_valid_q, out_valid_d;
    logic [CHANNELS*PH_WIDTH-1:0]  out_phase_q, out_phase_d;
    logic [CHANNELS-1:0]           out_timeout_q, out_timeout_d;
    logic [15:0]                   out_run_q, out_run_d;
    logic [7:0]                    ovr_q, ovr_d;
    logic                          run_last;
    logic                          close;

    pr_period_cnt #(.CNT_WIDTH(CNT_WIDTH)) u_period_cnt (
        .clk       (clk),
        .reset     (reset),
        .en        (state_q != ST_IDLE),
        .start_en  (state_q == ST_RUN),
        .cfg_period(cfg_period),
        .start     (start),
        .last      (run_last)
    );

    // cap_q only ever holds masked channels, so equality means every participant reported.
    assign close = run_open_q && ((cap_q == mask_q) || run_last);

    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        rem_d   = rem_q;
        case (state_q)
            ST_IDLE: begin
                if (cfg_mode == MODE_CONT) begin
                    state_d = ST_RUN;
                    mode_d  = MODE_CONT;
                end else if (cfg_arm && (cfg_mode == MODE_BURST)) begin
                    state_d = ST_RUN;
                    mode_d  = MODE_BURST;
                    rem_d   = RW'(RUNS);
                end else if (cfg_arm && (cfg_mode == MODE_SINGLE)) begin
                    state_d = ST_RUN;
                    mode_d  = MODE_SINGLE;
                    rem_d   = RW'(1);
                end
            end
            ST_RUN: begin
                if (start && (mode_q != MODE_CONT)) begin
                    rem_d = rem_q - RW'(1);
                    if (rem_q == RW'(1)) begin
                        state_d = ST_DRAIN;
                    end
                end else if (run_last && ((cfg_mode == MODE_IDLE) ||
                             ((mode_q == MODE_CONT) && (cfg_mode != MODE_CONT)))) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (close || !run_open_q) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        run_idx_d     = run_idx_q;
        cur_run_d     = cur_run_q;
        run_open_d    = run_open_q;
        mask_d        = mask_q;
        cap_d         = cap_q;
        ph_d          = ph_q;
        out_valid_d   = out_valid_q;
        out_phase_d   = out_phase_q;
        out_timeout_d = out_timeout_q;
        out_run_d     = out_run_q;
        ovr_d         = ovr_q;

        // Strobes in the start cycle fall through: run_open_q is still low there.
        if (start) begin
            run_open_d = 1'b1;
            mask_d     = ch_mask;
            cap_d      = '0;
            ph_d       = '0;
            cur_run_d  = run_idx_q;
            run_idx_d  = run_idx_q + 16'd1;
        end else if (close) begin
            run_open_d = 1'b0;
        end else if (run_open_q) begin
            for (int i = 0; i < CHANNELS; i++) begin
                if (mask_q[i] && ch_valid[i] && !cap_q[i]) begin
                    cap_d[i]                   = 1'b1;
                    ph_d[i*PH_WIDTH +: PH_WIDTH] = ch_phase[i*PH_WIDTH +: PH_WIDTH];
                end
            end
        end

        if (close) begin
            if (!out_valid_q || out_ready) begin
                out_valid_d   = 1'b1;
                out_phase_d   = ph_q;
                out_timeout_d = mask_q & ~cap_q;
                out_run_d     = cur_run_q;
            end else if (ovr_q != 8'hFF) begin
                ovr_d = ovr_q + 8'd1;
            end
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            mode_q        <= MODE_IDLE;
            rem_q         <= '0;
            run_idx_q     <= '0;
            cur_run_q     <= '0;
            run_open_q    <= 1'b0;
            mask_q        <= '0;
            cap_q         <= '0;
            ph_q          <= '0;
            out_valid_q   <= 1'b0;
            out_phase_q   <= '0;
            out_timeout_q <= '0;
            out_run_q     <= '0;
            ovr_q         <= '0;
        end else begin
            state_q       <= state_d;
            mode_q        <= mode_d;
            rem_q         <= rem_d;
            run_idx_q     <= run_idx_d;
            cur_run_q     <= cur_run_d;
            run_open_q    <= run_open_d;
            mask_q        <= mask_d;
            cap_q         <= cap_d;
            ph_q          <= ph_d;
            out_valid_q   <= out_valid_d;
            out_phase_q   <= out_phase_d;
            out_timeout_q <= out_timeout_d;
            out_run_q     <= out_run_d;
            ovr_q         <= ovr_d;
        end
    end

    generate
        for (genvar gi = 0; gi < CHANNELS - 1; gi++) begin : g_diff
            assign out_diff[gi*PH_WIDTH +: PH_WIDTH] =
                out_phase_q[(gi+1)*PH_WIDTH +: PH_WIDTH] - out_phase_q[0 +: PH_WIDTH];
        end
    endgenerate

    assign out_valid   = out_valid_q;
    assign out_phase   = out_phase_q;
    assign out_timeout = out_timeout_q;
    assign out_run     = out_run_q;
    assign overrun_cnt = ovr_q;
    assign busy        = (state_q != ST_IDLE);

endmodule

// File: tb/tb_pr_run_ctrl.sv
// Directed bench for pr_run_ctrl: continuous, single, burst, overrun,
// load-on-accept and mid-run reset scenarios with hand-computed results.
module tb_pr_run_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  cfg_mode;
    logic        cfg_arm;
    logic [15:0] cfg_period;
    logic [2:0]  ch_mask;
    logic        start;
    logic [2:0]  ch_valid;
    logic [47:0] ch_phase;
    logic        out_valid;
    logic        out_ready;
    logic [47:0] out_phase;
    logic [31:0] out_diff;
    logic [2:0]  out_timeout;
    logic [15:0] out_run;
    logic [7:0]  overrun_cnt;
    logic        busy;

    int checks   = 0;
    int failures = 0;

    pr_run_ctrl #(.CHANNELS(3), .PH_WIDTH(16), .CNT_WIDTH(16), .RUNS(3)) dut (
        .clk        (clk),
        .reset      (reset),
        .cfg_mode   (cfg_mode),
        .cfg_arm    (cfg_arm),
        .cfg_period (cfg_period),
        .ch_mask    (ch_mask),
        .start      (start),
        .ch_valid   (ch_valid),
        .ch_phase   (ch_phase),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_phase  (out_phase),
        .out_diff   (out_diff),
        .out_timeout(out_timeout),
        .out_run    (out_run),
        .overrun_cnt(overrun_cnt),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; cfg_mode = 2'd0; cfg_arm = 1'b0; cfg_period = 16'd9;
        ch_mask = 3'b000; ch_valid = 3'b000; ch_phase = '0; out_ready = 1'b0;
        repeat (3) tick();
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        checks++; if (start !== 1'b0) begin failures++; $display("FAIL reset_start got=%b exp=0", start); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if ({out_phase, out_diff, out_timeout, out_run, overrun_cnt} !== '0) begin
            failures++; $display("FAIL reset_outputs got=%h exp=0", {out_phase, out_diff, out_timeout, out_run, overrun_cnt});
        end
        reset = 1'b0;
        cfg_arm = 1'b1;
        tick();
        cfg_arm = 1'b0;
        tick();
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL idle_arm_mode0 busy got=%b exp=0", busy); end
    endtask

    task automatic test_continuous();
        logic [47:0] ph [2];
        logic [31:0] df [2];
        ph[0] = {16'h0F00, 16'h1100, 16'h1000}; df[0] = {16'hFF00, 16'h0100};
        ph[1] = {16'h0000, 16'h8010, 16'h7FF0}; df[1] = {16'h8010, 16'h0020};
        cfg_period = 16'd9; ch_mask = 3'b111; out_ready = 1'b1; cfg_mode = 2'd1;
        tick();
        for (int r = 0; r < 2; r++) begin
            for (int c = 0; c < 10; c++) begin
                if (r == 1 && c == 5) cfg_mode = 2'd0;
                checks++; if (start !== (c == 0)) begin failures++; $display("FAIL cont_start r=%0d c=%0d got=%b", r, c, start); end
                checks++; if (out_valid !== (c == 6)) begin failures++; $display("FAIL cont_out_valid r=%0d c=%0d got=%b", r, c, out_valid); end
                if (c == 6) begin
                    $display("cont result run=%0d phase=%h diff=%h timeout=%b", out_run, out_phase, out_diff, out_timeout);
                    checks++; if (out_phase !== ph[r]) begin failures++; $display("FAIL cont_phase got=%h exp=%h", out_phase, ph[r]); end
                    checks++; if (out_diff !== df[r]) begin failures++; $display("FAIL cont_diff got=%h exp=%h", out_diff, df[r]); end
                    checks++; if (out_timeout !== 3'b000) begin failures++; $display("FAIL cont_timeout got=%b exp=000", out_timeout); end
                    checks++; if (out_run !== 16'(r)) begin failures++; $display("FAIL cont_run got=%0d exp=%0d", out_run, r); end
                end
                ch_valid = (c == 4) ? 3'b111 : 3'b000;
                ch_phase = ph[r];
                tick();
            end
        end
        ch_valid = 3'b000;
        checks++; if (start !== 1'b0 || busy !== 1'b1) begin failures++; $display("FAIL cont_drain start=%b busy=%b exp start=0 busy=1", start, busy); end
        tick();
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL cont_idle busy got=%b exp=0", busy); end
    endtask

    task automatic test_single_timeout();
        cfg_period = 16'd9; ch_mask = 3'b111; out_ready = 1'b0; cfg_mode = 2'd3; cfg_arm = 1'b1;
        tick();
        cfg_arm = 1'b0;
        for (int c = 0; c < 10; c++) begin
            checks++; if (start !== (c == 0)) begin failures++; $display("FAIL single_start c=%0d got=%b", c, start); end
            if (c == 9) begin
                checks++; if (out_valid !== 1'b0 || busy !== 1'b1) begin failures++; $display("FAIL single_close_cycle valid=%b busy=%b exp 0/1", out_valid, busy); end
            end
            ch_valid = (c == 2) ? 3'b011 : 3'b000;
            ch_phase = {16'h3333, 16'h2222, 16'h1111};
            tick();
        end
        ch_valid = 3'b000;
        $display("single result run=%0d phase=%h diff=%h timeout=%b", out_run, out_phase, out_diff, out_timeout);
        checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL single_valid got=%b exp=1", out_valid); end
        checks++; if (out_timeout !== 3'b100) begin failures++; $display("FAIL single_timeout got=%b exp=100", out_timeout); end
        checks++; if (out_phase !== {16'h0000, 16'h2222, 16'h1111}) begin failures++; $display("FAIL single_phase got=%h exp=000022221111", out_phase); end
        checks++; if (out_diff !== {16'hEEEF, 16'h1111}) begin failures++; $display("FAIL single_diff got=%h exp=eeef1111", out_diff); end
        checks++; if (out_run !== 16'd2 || busy !== 1'b0) begin failures++; $display("FAIL single_run_busy run=%0d busy=%b exp 2/0", out_run, busy); end
        out_ready = 1'b1;
        tick();
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL single_accept valid=%b exp=0", out_valid); end
    endtask

    task automatic test_burst();
        int nstart = 0;
        int nres = 0;
        int busy_low_t = -1;
        int start_t [3];
        cfg_period = 16'd1; ch_mask = 3'b101; out_ready = 1'b1; cfg_mode = 2'd2; cfg_arm = 1'b1;
        tick();
        cfg_arm = 1'b0;
        for (int t = 0; t < 30; t++) begin
            if (start) begin
                if (nstart < 3) start_t[nstart] = t;
                nstart++;
            end
            if (out_valid) begin
                $display("burst result t=%0d run=%0d phase=%h diff=%h timeout=%b", t, out_run, out_phase, out_diff, out_timeout);
                checks++; if (out_timeout !== 3'b000) begin failures++; $display("FAIL burst_timeout got=%b exp=000", out_timeout); end
                checks++; if (out_run !== 16'(3 + nres)) begin failures++; $display("FAIL burst_run got=%0d exp=%0d", out_run, 3 + nres); end
                checks++; if (out_phase !== {16'h0030, 16'h0000, 16'h0010}) begin failures++; $display("FAIL burst_phase got=%h exp=003000000010", out_phase); end
                checks++; if (out_diff !== {16'h0020, 16'hFFF0}) begin failures++; $display("FAIL burst_diff got=%h exp=0020fff0", out_diff); end
                nres++;
            end
            if (!busy && busy_low_t < 0) busy_low_t = t;
            cfg_arm  = (t == 5);
            ch_valid = (t < 12 && (t % 4) == 1) ? 3'b111 : 3'b000;
            ch_phase = {16'h0030, 16'h5555, 16'h0010};
            tick();
        end
        cfg_arm = 1'b0; ch_valid = 3'b000;
        checks++; if (nstart !== 3) begin failures++; $display("FAIL burst_starts got=%0d exp=3", nstart); end
        for (int k = 0; k < 3; k++) begin
            checks++; if (nstart > k && start_t[k] !== 4 * k) begin failures++; $display("FAIL burst_start_time k=%0d got=%0d exp=%0d", k, start_t[k], 4 * k); end
        end
        checks++; if (nres !== 3) begin failures++; $display("FAIL burst_results got=%0d exp=3", nres); end
        checks++; if (busy_low_t !== 11) begin failures++; $display("FAIL burst_busy_low got=%0d exp=11", busy_low_t); end
    endtask

    task automatic test_overrun();
        int nstart = 0;
        cfg_period = 16'd3; ch_mask = 3'b000; out_ready = 1'b0; cfg_mode = 2'd1;
        tick();
        for (int t = 0; t < 1200; t++) begin
            if (t == 1199) cfg_mode = 2'd0;
            if (start) nstart++;
            if (t == 2) begin
                checks++; if (out_valid !== 1'b1 || out_run !== 16'd6) begin failures++; $display("FAIL ovr_first valid=%b run=%0d exp 1/6", out_valid, out_run); end
            end
            if (t == 402) begin
                checks++; if (overrun_cnt !== 8'd100) begin failures++; $display("FAIL ovr_mid got=%0d exp=100", overrun_cnt); end
            end
            tick();
        end
        $display("overrun runs=%0d held_run=%0d overrun_cnt=%0d", nstart, out_run, overrun_cnt);
        checks++; if (nstart !== 300) begin failures++; $display("FAIL ovr_starts got=%0d exp=300", nstart); end
        checks++; if (overrun_cnt !== 8'd255) begin failures++; $display("FAIL ovr_saturate got=%0d exp=255", overrun_cnt); end
        checks++; if (out_valid !== 1'b1 || out_run !== 16'd6) begin failures++; $display("FAIL ovr_held valid=%b run=%0d exp 1/6", out_valid, out_run); end
        checks++; if (start !== 1'b0 || busy !== 1'b1) begin failures++; $display("FAIL ovr_drain start=%b busy=%b exp 0/1", start, busy); end
        tick();
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL ovr_idle busy=%b exp=0", busy); end
    endtask

    task automatic test_back_to_back();
        cfg_mode = 2'd1;
        tick();
        tick();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        cfg_mode = 2'd0;
        $display("b2b result run=%0d valid=%b overrun_cnt=%0d", out_run, out_valid, overrun_cnt);
        checks++; if (out_valid !== 1'b1 || out_run !== 16'd306) begin failures++; $display("FAIL b2b_load valid=%b run=%0d exp 1/306", out_valid, out_run); end
        repeat (3) tick();
        checks++; if (busy !== 1'b0 || out_valid !== 1'b1 || out_run !== 16'd306) begin
            failures++; $display("FAIL b2b_hold busy=%b valid=%b run=%0d exp 0/1/306", busy, out_valid, out_run);
        end
    endtask

    task automatic test_reset_midrun();
        int nstart = 0;
        cfg_period = 16'd9; ch_mask = 3'b111; cfg_mode = 2'd3; cfg_arm = 1'b1;
        tick();
        cfg_arm = 1'b0;
        ch_valid = 3'b001; ch_phase = {16'h0003, 16'h0002, 16'h0001};
        tick();
        ch_valid = 3'b000;
        tick();
        tick();
        #2 reset = 1'b1;
        #1;
        checks++; if ({out_valid, busy, start} !== 3'b000) begin failures++; $display("FAIL rst_mid_flags got=%b exp=000", {out_valid, busy, start}); end
        checks++; if ({out_phase, out_diff, out_timeout, out_run, overrun_cnt} !== '0) begin
            failures++; $display("FAIL rst_mid_data got=%h exp=0", {out_phase, out_diff, out_timeout, out_run, overrun_cnt});
        end
        tick();
        tick();
        reset = 1'b0;
        for (int t = 0; t < 20; t++) begin
            if (start) nstart++;
            tick();
        end
        checks++; if (nstart !== 0 || busy !== 1'b0) begin failures++; $display("FAIL rst_no_restart starts=%0d busy=%b exp 0/0", nstart, busy); end
        ch_mask = 3'b000; out_ready = 1'b1; cfg_arm = 1'b1;
        tick();
        cfg_arm = 1'b0;
        checks++; if (start !== 1'b1) begin failures++; $display("FAIL rst_rearm_start got=%b exp=1", start); end
        tick();
        tick();
        $display("rearm result run=%0d valid=%b overrun_cnt=%0d", out_run, out_valid, overrun_cnt);
        checks++; if (out_valid !== 1'b1 || out_run !== 16'd0 || overrun_cnt !== 8'd0) begin
            failures++; $display("FAIL rst_rearm_result valid=%b run=%0d ovr=%0d exp 1/0/0", out_valid, out_run, overrun_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_continuous();
        test_single_timeout();
        test_burst();
        test_overrun();
        test_back_to_back();
        test_reset_midrun();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pr_run_ctrl.md
PR_RUN_CTRL -- requirements
Module: pr_run_ctrl

Interface
REQ-001 SHALL have parameter CHANNELS, default 3, number of antenna channels (2..8).
REQ-002 SHALL have parameter PH_WIDTH, default 16, phase word width, Q1.(PH_WIDTH-1) fraction of pi.
REQ-003 SHALL have parameter CNT_WIDTH, default 16, run-period counter width.
REQ-004 SHALL have parameter RUNS, default 3, number of runs per burst.
REQ-005 SHALL have port clk, input, 1, the single clock; all logic on its rising edge.
REQ-006 SHALL have port reset, input, 1, reset, asynchronous, active-high.
REQ-007 SHALL have port cfg_mode, input, 2, mode: 0 idle, 1 continuous, 2 burst, 3 single.
REQ-008 SHALL have port cfg_arm, input, 1, one-cycle pulse that launches burst/single.
REQ-009 SHALL have port cfg_period, input, CNT_WIDTH, run length minus one in clk cycles.
REQ-010 SHALL have port ch_mask, input, CHANNELS, 1 = channel participates.
REQ-011 SHALL have port start, output, 1, one-cycle run-start pulse to the phase_extract sink_start inputs.
REQ-012 SHALL have port ch_valid, input, CHANNELS, per-channel result strobe.
REQ-013 SHALL have port ch_phase, input, CHANNELS*PH_WIDTH, per-channel signed phase.
REQ-014 SHALL have port out_valid / out_ready, output / input, 1 each, result handshake.
REQ-015 SHALL have port out_phase, output, CHANNELS*PH_WIDTH, captured phases.
REQ-016 SHALL have port out_diff, output, (CHANNELS-1)*PH_WIDTH, phase[k+1]-phase[0].
REQ-017 SHALL have port out_timeout, output, CHANNELS, masked channels missing at run close.
REQ-018 SHALL have port out_run, output, 16, run index of the result.
REQ-019 SHALL have port overrun_cnt, output, 8, dropped results; busy, output, 1, run active.

Function
REQ-020 FSM states SHALL be IDLE, RUN, DRAIN; IDLE->RUN on cfg_mode==1, or on cfg_arm with cfg_mode 2/3.
REQ-021 In RUN, period counter SHALL count 0..max(cfg_period,3) and wrap; cfg_period sampled at count 0.
REQ-022 start SHALL pulse in every count-0 cycle; run index SHALL increment (wrap 16 bits) per start.
REQ-023 A masked channel's first ch_valid after start SHALL capture its ch_phase; later strobes, unmasked strobes and strobes in the start cycle SHALL be ignored.
REQ-024 Run SHALL close in the cycle all masked channels are captured, or at count==period, whichever first; ch_mask all-zero closes in the cycle after start.
REQ-025 Result SHALL be loaded into the output register the cycle after close; out_timeout = mask AND NOT captured.
REQ-026 out_diff SHALL be modulo-2^PH_WIDTH subtraction (natural phase wrap), no saturation.
REQ-027 out_valid SHALL hold with stable data until out_ready; a load in the same cycle as acceptance SHALL succeed.
REQ-028 If the output register is full and not being accepted at load, the new result SHALL be dropped and overrun_cnt incremented, saturating at 255.
REQ-029 Burst SHALL issue exactly RUNS starts; single exactly one; after the last start -> DRAIN.
REQ-030 cfg_mode changes SHALL act only at run boundaries; mode 0 during RUN -> DRAIN.
REQ-031 DRAIN SHALL finish the open run (close and load) then go to IDLE; cfg_arm outside IDLE ignored.
REQ-032 busy SHALL be high in RUN and DRAIN.

Reset
REQ-033 Reset SHALL force IDLE, counter 0, run index 0, captures cleared, and all outputs 0.
REQ-034 Reset mid-run SHALL discard the open run and any pending result with no overrun count.

Structure
REQ-035 Package pr_pkg SHALL hold the mode and state enums and the minimum-period constant 3.
REQ-036 Period counter and start generator SHALL be sub-module pr_period_cnt; capture/output logic stays in pr_run_ctrl.

Verification
REQ-037 Continuous, period 9, mask 111, all valid at count 4 -> start every 10 cycles, out_valid at count 6, timeout 000.
REQ-038 Burst RUNS=3, mask 101, ch1 never valid -> 3 starts, 3 results, timeout 000 (ch1 masked), busy low after third.
REQ-039 Mask 111, ch2 silent, period 9 -> close at count 9, out_timeout 100, load next cycle.
REQ-040 phase0=0x7FF0, phase1=0x8010 -> out_diff[0]=0x0020.
REQ-041 out_ready held low across 300 runs -> first result held, overrun_cnt saturates at 255.
REQ-042 Reset asserted mid-collect -> all outputs 0 immediately; no start until re-armed.
